// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared state type, buffer depth and width helpers for the ROM stream reader
package rom_stream_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/rom_stream_skid.sv
// rom_stream_skid: 2-entry FIFO of {last, data} with head register output and same-cycle push+pop
module rom_stream_skid import rom_stream_pkg::*; #(
  parameter int W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [OCC_W-1:0] occ
);
  logic [W-1:0] m0, m1;
  logic [OCC_W-1:0] wi;
  assign dout = m0;
  assign wi = occ - OCC_W'(pop);
  // head shifts on pop; the incoming word lands in the first free slot after the pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
      occ <= '0;
    end else begin
      if (pop) m0 <= m1;
      if (push && wi == '0) m0 <= din;
      if (push && wi == OCC_W'(1)) m1 <= din;
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a wrapping run of ROM addresses and streams the words out as valid/ready with last
module rom_stream_reader import rom_stream_pkg::*; #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int FIFO_D = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [cnt_w(ADDR_W)-1:0] count,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);
  localparam int CW = cnt_w(ADDR_W);
  state_t st, nst;
  logic [ADDR_W-1:0] rd_addr, ia;
  logic [CW-1:0] rem, ic;
  logic [OCC_W-1:0] occ;
  logic [DATA_W:0] hd;
  logic go, fire, pop, push, inflight, il, ret, rl;
  assign pop = out_valid && out_ready;
  assign out_valid = occ != '0;
  assign {out_last, out_data} = hd;
  // a returned word waits in the ROM output while the buffer is full; no read was issued behind it, so rom_addr and rom_data stay put
  assign push = ret && (occ < OCC_W'(FIFO_D) || pop);
  // the accepting start issues the first read itself; later reads need a free buffer slot counting the word in flight
  always_comb begin
    go = st == IDLE && start;
    ia = go ? base_addr : rd_addr;
    ic = go ? count : rem;
    fire = ic != '0 && (go || (st == FETCH && 3'(occ) + 3'(inflight) - 3'(pop) < 3'(FIFO_D)));
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nst;
  // next state: the run ends when the word tagged last leaves the stream
  always_comb
    nst = st == IDLE  ? (start ? (count != '0 ? FETCH : DONE) : IDLE) :
          st == FETCH ? (rem == '0 ? DRAIN : FETCH) :
          st == DRAIN ? (pop && out_last ? DONE : DRAIN) : IDLE;
  // status outputs decoded from state
  always_comb begin
    busy = st == FETCH || st == DRAIN;
    done = st == DONE;
  end
  // address walk, remaining count and the two-stage read return pipeline
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr <= '0;
      rd_addr <= '0;
      rem <= '0;
      inflight <= 1'b0;
      il <= 1'b0;
      ret <= 1'b0;
      rl <= 1'b0;
    end else begin
      inflight <= fire;
      il <= fire && ic == CW'(1);
      if (!ret || push) begin
        ret <= inflight;
        rl <= il;
      end
      if (fire) begin
        rom_addr <= ia;
        rd_addr <= ia + 1'b1;
        rem <= ic - 1'b1;
      end
    end
  rom_stream_skid #(.W(DATA_W + 1)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({rl, rom_data}),
    .dout(hd),
    .occ(occ)
  );
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: randomized scoreboard bench for rom_stream_reader against a list-of-words reference model
module tb_rom_stream_reader;
  typedef struct {logic last; logic [15:0] d;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
  logic [2:0] base_addr = 0, rom_addr;
  logic [3:0] count = 0;
  logic [15:0] rom_data, out_data;
  logic out_valid, out_last, busy, done;
  logic [15:0] rom [8];
  exp_t q[$];
  exp_t e;
  int pass_n = 0, tot_n = 0, rmode = 0;
  bit zero_req = 0, pv = 0, ed = 0, nd = 0;
  logic [15:0] pd;

  rom_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  initial begin
    int stall = 0;
    forever begin
      @(posedge clk); #1;
      if (rmode == 0) out_ready = 1;
      else if (stall > 0) begin out_ready = 0; stall--; end
      else if ($urandom_range(3) == 0) begin out_ready = 0; stall = 2; end
      else out_ready = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pv = 0;
      ed = 0;
    end else begin
      if (done || ed) chk("done_pulse", done, ed);
      if (ed) chk("busy_low_at_done", busy, 0);
      if (pv) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
      end
      nd = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tot_n++;
          $display("FAIL extra_word: got %h, expected no word", out_data);
        end else begin
          e = q.pop_front();
          chk("data", out_data, e.d);
          chk("last", out_last, e.last);
          nd = out_last;
        end
      end
      ed = nd || (start && zero_req);
      pv = out_valid && !out_ready;
      pd = out_data;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    if (!done) begin
      tot_n++;
      $display("FAIL timeout: done not seen after %0d cycles, expected a done pulse", n);
    end
    @(posedge clk);
  endtask

  task automatic issue(input int b, input int c);
    @(posedge clk); #1;
    base_addr = 3'(b);
    count = 4'(c);
    start = 1;
    zero_req = c == 0;
    for (int i = 0; i < c; i++) q.push_back('{i == c - 1, rom[3'(b + i)]});
    @(posedge clk); #1;
    start = 0;
    zero_req = 0;
  endtask

  task automatic run(input int b, input int c, input int m, input bit lat, input bit dbl);
    rmode = m;
    issue(b, c);
    if (lat) begin
      @(negedge clk);
      chk("lat_cycle0_valid", out_valid, 0);
      chk("busy_rise", busy, 1);
      @(negedge clk);
      chk("lat_cycle1_valid", out_valid, 0);
      @(negedge clk);
      chk("lat_cycle2_valid", out_valid, 1);
    end
    if (dbl) begin
      @(posedge clk); #1;
      base_addr = 3;
      count = 5;
      start = 1;
      chk("busy_at_restart", busy, 1);
      @(posedge clk); #1;
      start = 0;
    end
    wait_done();
  endtask

  initial begin
    rom = '{16'habcd, 16'h79ca, 16'h1358, 16'h976a, 16'h84ad, 16'hd3f5, 16'hf4a2, 16'hc0d1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    run(2, 3, 0, 1, 0);
    run(6, 4, 0, 1, 0);
    run(0, 8, 1, 0, 1);
    run(0, 0, 0, 0, 0);
    chk("zero_count_no_valid", out_valid, 0);
    rmode = 0;
    issue(4, 6);
    begin
      int n = 0;
      while (q.size() > 4 && n < 50) begin @(posedge clk); #1; n++; end
      chk("two_transfers_before_reset", q.size() <= 4, 1);
    end
    rst_n = 0;
    #1;
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_held_done", done, 0);
    rst_n = 1;
    run(1, 1, 0, 0, 0);
    run(0, 10, 0, 1, 0);
    for (int k = 0; k < 6; k++) run($urandom_range(7), $urandom_range(15, 1), $urandom_range(1), 0, 0);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
